// File: rtl/fp51_loader_pkg.sv
// ============================================================================
// Module : fp51_loader_pkg
// Brief  : Shared codes, status and state encodings for the FP51 boot loader.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp51_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h5A;
  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;
  localparam logic [7:0] CMD_PAUSE = 8'h03;

  typedef enum logic [1:0] {
    STATUS_OK       = 2'd0,
    STATUS_BAD_CSUM = 2'd1,
    STATUS_TIMEOUT  = 2'd2,
    STATUS_BAD_CMD  = 2'd3
  } status_e;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_CMD        = 4'd1,
    S_ADDR_H     = 4'd2,
    S_ADDR_L     = 4'd3,
    S_LEN        = 4'd4,
    S_CSUM       = 4'd5,
    S_STALL_WAIT = 4'd6,
    S_DATA       = 4'd7,
    S_RUN        = 4'd8,
    S_RESP       = 4'd9
  } state_e;

  function automatic logic is_valid_cmd(input logic [7:0] c);
    return (c == CMD_LOAD) || (c == CMD_RUN) || (c == CMD_PAUSE);
  endfunction

  function automatic logic accepts_byte(input state_e s);
    return s inside {S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L, S_LEN, S_DATA, S_CSUM};
  endfunction

  // Inter-byte timer runs only while a frame is waiting on the byte source.
  function automatic logic timer_runs(input state_e s);
    return s inside {S_CMD, S_ADDR_H, S_ADDR_L, S_LEN, S_DATA, S_CSUM};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp51_byte_to_word_packer.sv
// ============================================================================
// Module : fp51_byte_to_word_packer
// Brief  : Packs little-endian bytes into 32-bit words, one-cycle word strobe.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp51_byte_to_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_last,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;

  // Shifting in from the top leaves the first byte in bits [7:0].
  always_comb begin
    idx_d   = idx_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear) begin
      idx_d = 2'd0;
    end else if (byte_valid) begin
      idx_d   = idx_q + 2'd1;
      word_d  = {byte_data, word_q[31:8]};
      valid_d = (idx_q == 2'd3);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= 2'd0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_last  = byte_valid && !clear && (idx_q == 2'd3);
  assign word_valid = valid_q;
  assign word_data  = word_q;

endmodule

`default_nettype wire

// File: rtl/fp51_boot_loader_ctrl.sv
// ============================================================================
// Module : fp51_boot_loader_ctrl
// Brief  : Framed byte-stream loader: pauses FP51, writes code words, resumes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp51_boot_loader_ctrl
  import fp51_loader_pkg::*;
#(
  parameter int PC_BITWIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  input  logic                   debug_stall,
  output logic                   pause,
  output logic                   run_pulse,
  output logic                   inst_mem_we,
  output logic [PC_BITWIDTH-3:0] inst_mem_wr_addr,
  output logic [31:0]            inst_mem_data_in,
  output logic                   resp_valid,
  output logic [1:0]             resp_status,
  output logic                   busy
);

  localparam int AW = PC_BITWIDTH - 2;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  status_e       resp_status_q, resp_status_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    word_cnt_q, word_cnt_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pause_q, pause_d;
  logic          run_pulse_q, run_pulse_d;
  logic          resp_valid_q, resp_valid_d;
  logic          busy_q, busy_d;
  logic          rx_ready_q, rx_ready_d;

  logic accept;
  logic timeout_hit;
  logic pk_byte_valid;
  logic pk_clear;
  logic pk_word_last;

  assign accept        = rx_valid && rx_ready_q;
  assign pk_byte_valid = accept && (state_q == S_DATA);
  assign pk_clear      = (state_q != S_DATA);
  // A byte landing on the terminal count cancels the timeout.
  assign timeout_hit   = timer_runs(state_q) && !accept && (timer_q == TIMER_LAST);

  fp51_byte_to_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear),
    .byte_valid (pk_byte_valid),
    .byte_data  (rx_data),
    .word_last  (pk_word_last),
    .word_valid (inst_mem_we),
    .word_data  (inst_mem_data_in)
  );

  always_comb begin
    state_d       = state_q;
    resp_status_d = resp_status_q;
    cmd_d         = cmd_q;
    len_d         = len_q;
    csum_d        = csum_q;
    word_cnt_d    = word_cnt_q;
    base_d        = base_q;
    wr_addr_d     = wr_addr_q;
    pause_d       = pause_q;

    if (accept) begin
      timer_d = '0;
    end else if (timer_runs(state_q)) begin
      timer_d = timer_q + TW'(1);
    end else if (state_q == S_IDLE) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q;
    end

    if (accept && (state_q inside {S_CMD, S_ADDR_H, S_ADDR_L, S_LEN, S_DATA})) begin
      csum_d = csum_q + rx_data;
    end

    case (state_q)
      S_IDLE: begin
        csum_d     = 8'd0;
        word_cnt_d = 8'd0;
        if (accept && (rx_data == SYNC_BYTE)) state_d = S_CMD;
      end
      S_CMD: begin
        if (accept) begin
          cmd_d = rx_data;
          if (is_valid_cmd(rx_data)) begin
            state_d = S_ADDR_H;
          end else begin
            state_d       = S_RESP;
            resp_status_d = STATUS_BAD_CMD;
          end
        end
      end
      S_ADDR_H: begin
        if (accept) begin
          base_d  = AW'({rx_data, 8'h00});
          state_d = S_ADDR_L;
        end
      end
      S_ADDR_L: begin
        if (accept) begin
          base_d  = base_q | AW'(rx_data);
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (accept) begin
          len_d = rx_data;
          if (cmd_q == CMD_LOAD) begin
            pause_d = 1'b1;
            state_d = S_STALL_WAIT;
          end else begin
            state_d = S_CSUM;
          end
        end
      end
      S_STALL_WAIT: begin
        // Shared by LOAD (before payload) and PAUSE (after checksum).
        if (debug_stall) begin
          if (cmd_q == CMD_PAUSE) begin
            state_d       = S_RESP;
            resp_status_d = STATUS_OK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (pk_word_last) begin
          wr_addr_d  = base_q + AW'(word_cnt_q);
          word_cnt_d = word_cnt_q + 8'd1;
          // LEN=0 wraps to 255 here, giving 256 words.
          if (word_cnt_q == (len_q - 8'd1)) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (rx_data != csum_q) begin
            state_d       = S_RESP;
            resp_status_d = STATUS_BAD_CSUM;
          end else if (cmd_q == CMD_PAUSE) begin
            pause_d = 1'b1;
            state_d = S_STALL_WAIT;
          end else if (cmd_q == CMD_RUN) begin
            pause_d = 1'b0;
            state_d = S_RUN;
          end else begin
            state_d       = S_RESP;
            resp_status_d = STATUS_OK;
          end
        end
      end
      S_RUN: begin
        state_d       = S_RESP;
        resp_status_d = STATUS_OK;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (timeout_hit) begin
      state_d       = S_RESP;
      resp_status_d = STATUS_TIMEOUT;
    end

    run_pulse_d  = (state_d == S_RUN);
    resp_valid_d = (state_d == S_RESP);
    busy_d       = (state_d != S_IDLE);
    rx_ready_d   = accepts_byte(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      resp_status_q <= STATUS_OK;
      cmd_q         <= 8'd0;
      len_q         <= 8'd0;
      csum_q        <= 8'd0;
      word_cnt_q    <= 8'd0;
      base_q        <= '0;
      wr_addr_q     <= '0;
      timer_q       <= '0;
      pause_q       <= 1'b0;
      run_pulse_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      rx_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      resp_status_q <= resp_status_d;
      cmd_q         <= cmd_d;
      len_q         <= len_d;
      csum_q        <= csum_d;
      word_cnt_q    <= word_cnt_d;
      base_q        <= base_d;
      wr_addr_q     <= wr_addr_d;
      timer_q       <= timer_d;
      pause_q       <= pause_d;
      run_pulse_q   <= run_pulse_d;
      resp_valid_q  <= resp_valid_d;
      busy_q        <= busy_d;
      rx_ready_q    <= rx_ready_d;
    end
  end

  assign rx_ready         = rx_ready_q;
  assign pause            = pause_q;
  assign run_pulse        = run_pulse_q;
  assign inst_mem_wr_addr = wr_addr_q;
  assign resp_valid       = resp_valid_q;
  assign resp_status      = resp_status_q;
  assign busy             = busy_q;

endmodule

`default_nettype wire
